// File: rtl/cpx_arb_pkg.sv
// ---------------------------------------------------------------------------
// cpx_arb_pkg
// Shared constants and types for the per-destination CPX arbiter.
//   NSRC      : number of packet sources (scache0-3 plus the IO bridge)
//   QDEPTH    : destination buffer credits and per-source queue depth
//   CRED_W    : width of the destination credit counter
//   CNT_W     : width of a per-source queue occupancy count
//   QPTR_W    : width of a per-source queue read/write pointer
//   PTR_W     : width of a source index / round-robin pointer
//   SRC_SC0..SRC_SC3, SRC_IO : source index constants
//   lockState_t : whether an atomic pair currently owns the destination
//   nextSrc() : round-robin increment of a source index, wrapping at NSRC
// ---------------------------------------------------------------------------
package cpx_arb_pkg;

    localparam int NSRC   = 5;
    localparam int QDEPTH = 2;

    localparam int CRED_W = $clog2(QDEPTH + 1);
    localparam int CNT_W  = $clog2(QDEPTH + 1);
    localparam int QPTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int PTR_W  = $clog2(NSRC);

    localparam int SRC_SC0 = 0;
    localparam int SRC_SC1 = 1;
    localparam int SRC_SC2 = 2;
    localparam int SRC_SC3 = 3;
    localparam int SRC_IO  = 4;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } lockState_t;

    function automatic logic [PTR_W-1:0] nextSrc(input logic [PTR_W-1:0] s);
        return (s == PTR_W'(NSRC - 1)) ? '0 : s + PTR_W'(1);
    endfunction

endpackage

// File: rtl/cpx_dest_arb_if.sv
// ---------------------------------------------------------------------------
// cpx_dest_arb_if
// Bundles the source request side and the core return side of one CPX
// destination arbiter.
//   src_req_cq      : per-source packet request pulse
//   src_atom_cq     : per-source atomic-first-half qualifier
//   spc_credit_ret  : destination freed one buffer entry
//   cpx_grant_ca    : registered one-hot source grant
//   cpx_data_rdy_cx : grant delayed one cycle, packet valid at the core
//   arb_err         : sticky protocol error
// Modports: master drives requests/credits (source side), slave is the
// arbiter itself.
// ---------------------------------------------------------------------------
interface cpx_dest_arb_if;
    import cpx_arb_pkg::*;

    logic [NSRC-1:0] src_req_cq;
    logic [NSRC-1:0] src_atom_cq;
    logic            spc_credit_ret;
    logic [NSRC-1:0] cpx_grant_ca;
    logic            cpx_data_rdy_cx;
    logic            arb_err;

    modport master (
        output src_req_cq,
        output src_atom_cq,
        output spc_credit_ret,
        input  cpx_grant_ca,
        input  cpx_data_rdy_cx,
        input  arb_err
    );

    modport slave (
        input  src_req_cq,
        input  src_atom_cq,
        input  spc_credit_ret,
        output cpx_grant_ca,
        output cpx_data_rdy_cx,
        output arb_err
    );

endinterface

// File: rtl/cpx_src_q.sv
// ---------------------------------------------------------------------------
// cpx_src_q
// Pending-packet queue for one CPX source. Only the atom bit of each packet
// is stored; the packet data itself travels in the CPX buffer chain.
//   clk, reset   : clock, synchronous active-high reset
//   push_i       : request from this source this cycle
//   pushAtom_i   : atom bit of the pushed request
//   pop_i        : this source was granted this cycle
//   headAtom_o   : atom bit of the oldest queued entry
//   tailAtom_o   : atom bit of the newest queued entry
//   empty_o      : no entry queued
//   overflow_o   : a request was dropped because the queue was full
// ---------------------------------------------------------------------------
module cpx_src_q
    import cpx_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic pushAtom_i,
    input  logic pop_i,
    output logic headAtom_o,
    output logic tailAtom_o,
    output logic empty_o,
    output logic overflow_o
);

    logic [QDEPTH-1:0] atomFifo_q;
    logic [QPTR_W-1:0] rdPtr_q;
    logic [QPTR_W-1:0] wrPtr_q;
    logic [CNT_W-1:0]  count_q;

    logic              full;
    logic              doPush;
    logic              doPop;
    logic [QPTR_W-1:0] tailIdx;

    function automatic logic [QPTR_W-1:0] qNext(input logic [QPTR_W-1:0] p);
        return (p == QPTR_W'(QDEPTH - 1)) ? '0 : p + QPTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(QDEPTH));
    assign empty_o = (count_q == '0);

    // A full queue still accepts a request in the cycle it is popped,
    // which keeps push-and-pop on a full queue count-neutral.
    assign doPop      = pop_i && !empty_o;
    assign doPush     = push_i && (!full || doPop);
    assign overflow_o = push_i && full && !doPop;

    assign tailIdx    = (wrPtr_q == '0) ? QPTR_W'(QDEPTH - 1) : wrPtr_q - QPTR_W'(1);
    assign headAtom_o = atomFifo_q[rdPtr_q];
    assign tailAtom_o = atomFifo_q[tailIdx];

    always_ff @(posedge clk) begin
        if (reset) begin
            atomFifo_q <= '0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            if (doPush) begin
                atomFifo_q[wrPtr_q] <= pushAtom_i;
                wrPtr_q             <= qNext(wrPtr_q);
            end
            if (doPop) begin
                rdPtr_q <= qNext(rdPtr_q);
            end
            if (doPush && !doPop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (doPop && !doPush) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpx_dest_arb.sv
// ---------------------------------------------------------------------------
// cpx_dest_arb
// Per-destination CPX arbiter: picks one of the four L2 banks or the IO
// bridge each cycle to return a packet to one SPARC core, subject to the
// destination's buffer credits and atomic-pair locking.
//   rclk   : clock
//   reset  : synchronous active-high reset
//   arbIf  : cpx_dest_arb_if.slave (requests, atom qualifiers, credit
//            return in; one-hot grant, data-ready and error out)
// Build option: CPX_ARB_ERR_EN enables the sticky protocol error checks
// (queue overflow, excess credit return, non-atom request behind an
// unpaired atom first half). Without it arb_err is tied low.
// ---------------------------------------------------------------------------
module cpx_dest_arb
    import cpx_arb_pkg::*;
(
    input  logic           rclk,
    input  logic           reset,
    cpx_dest_arb_if.slave  arbIf
);

    logic [NSRC-1:0]   qEmpty;
    logic [NSRC-1:0]   qHeadAtom;
    logic [NSRC-1:0]   qTailAtom;
    logic [NSRC-1:0]   qOverflow;

    logic [NSRC-1:0]   eligible;
    logic [NSRC-1:0]   grant_d;
    logic [NSRC-1:0]   grant_q;
    logic              dataRdy_q;
    logic              anyGrant;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W-1:0]  searchIdx;

    logic [CRED_W-1:0] credit_q;
    logic [CRED_W-1:0] credit_d;
    logic [PTR_W-1:0]  rrPtr_q;
    logic [PTR_W-1:0]  rrPtr_d;
    lockState_t        lockState_q;
    lockState_t        lockState_d;
    logic [PTR_W-1:0]  lockSrc_q;
    logic [PTR_W-1:0]  lockSrc_d;

    logic              creditRet;
    assign creditRet = arbIf.spc_credit_ret;

    genvar g;
    generate
        for (g = 0; g < NSRC; g++) begin : gSrcQ
            cpx_src_q uSrcQ (
                .clk        (rclk),
                .reset      (reset),
                .push_i     (arbIf.src_req_cq[g]),
                .pushAtom_i (arbIf.src_atom_cq[g]),
                .pop_i      (grant_d[g]),
                .headAtom_o (qHeadAtom[g]),
                .tailAtom_o (qTailAtom[g]),
                .empty_o    (qEmpty[g]),
                .overflow_o (qOverflow[g])
            );
        end
    endgenerate

    // Round-robin pick: walk NSRC slots starting at the pointer and take the
    // first eligible source. While an atomic pair holds the lock only the
    // locked source can be eligible, so everyone else stalls.
    always_comb begin
        eligible  = '0;
        grant_d   = '0;
        anyGrant  = 1'b0;
        winner    = '0;
        searchIdx = rrPtr_q;
        for (int i = 0; i < NSRC; i++) begin
            eligible[i] = !qEmpty[i] && (credit_q != '0) &&
                          ((lockState_q == ARB_OPEN) || (lockSrc_q == PTR_W'(i)));
        end
        for (int i = 0; i < NSRC; i++) begin
            if (!anyGrant && eligible[searchIdx]) begin
                anyGrant = 1'b1;
                winner   = searchIdx;
            end
            searchIdx = nextSrc(searchIdx);
        end
        if (anyGrant) begin
            grant_d[winner] = 1'b1;
        end
    end

    // Lock, pointer and credit next state. Granting an atom first half takes
    // the lock and leaves the pointer alone so the pair's second packet is
    // the next thing granted; any other grant releases the lock and moves
    // the pointer past the winner.
    always_comb begin
        lockState_d = lockState_q;
        lockSrc_d   = lockSrc_q;
        rrPtr_d     = rrPtr_q;
        credit_d    = credit_q;
        if (anyGrant) begin
            if (qHeadAtom[winner]) begin
                lockState_d = ARB_LOCKED;
                lockSrc_d   = winner;
            end else begin
                lockState_d = ARB_OPEN;
                rrPtr_d     = nextSrc(winner);
            end
        end
        if (anyGrant && !creditRet) begin
            credit_d = credit_q - CRED_W'(1);
        end else if (!anyGrant && creditRet && (credit_q != CRED_W'(QDEPTH))) begin
            credit_d = credit_q + CRED_W'(1);
        end
    end

    // Grant is registered; data-ready is the grant one cycle later.
    always_ff @(posedge rclk) begin
        if (reset) begin
            grant_q     <= '0;
            dataRdy_q   <= 1'b0;
            credit_q    <= CRED_W'(QDEPTH);
            rrPtr_q     <= '0;
            lockState_q <= ARB_OPEN;
            lockSrc_q   <= '0;
        end else begin
            grant_q     <= grant_d;
            dataRdy_q   <= |grant_q;
            credit_q    <= credit_d;
            rrPtr_q     <= rrPtr_d;
            lockState_q <= lockState_d;
            lockSrc_q   <= lockSrc_d;
        end
    end

    assign arbIf.cpx_grant_ca    = grant_q;
    assign arbIf.cpx_data_rdy_cx = dataRdy_q;

`ifdef CPX_ARB_ERR_EN
    logic errEvent;
    logic arbErr_q;

    assign errEvent = (|qOverflow) ||
                      (creditRet && (credit_q == CRED_W'(QDEPTH))) ||
                      (|(arbIf.src_req_cq & ~arbIf.src_atom_cq & ~qEmpty & qTailAtom));

    // Sticky until reset.
    always_ff @(posedge rclk) begin
        if (reset) begin
            arbErr_q <= 1'b0;
        end else if (errEvent) begin
            arbErr_q <= 1'b1;
        end
    end

    assign arbIf.arb_err = arbErr_q;
`else
    logic unusedChecks;
    assign unusedChecks  = ^{qOverflow, qTailAtom};
    assign arbIf.arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpx_dest_arb.sv
// ---------------------------------------------------------------------------
// tb_cpx_dest_arb
// Directed bench for cpx_dest_arb. Each stimulus row drives one cycle of
// requests/credit return and then checks the grant and data-ready seen in
// the following cycle against hand-computed values.
// ---------------------------------------------------------------------------
module tb_cpx_dest_arb;
    import cpx_arb_pkg::*;

    logic rclk  = 1'b0;
    logic reset = 1'b1;

    int assertCount = 0;
    int failCount   = 0;

`ifdef CPX_ARB_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    // Free-running clock, 10 time-unit period.
    always #5 rclk = ~rclk;

    cpx_dest_arb_if arbIf ();

    cpx_dest_arb dut (
        .rclk  (rclk),
        .reset (reset),
        .arbIf (arbIf)
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge so outputs are settled.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Drive one cycle of inputs, then check the outputs of the next cycle.
    task automatic applyStimulus(input string tag, input logic [4:0] req,
                                 input logic [4:0] atom, input logic cr,
                                 input logic [4:0] expGrant, input logic expRdy);
        arbIf.src_req_cq     = req;
        arbIf.src_atom_cq    = atom;
        arbIf.spc_credit_ret = cr;
        tick();
        checkOutput({tag, ".grant"}, 32'(arbIf.cpx_grant_ca), 32'(expGrant));
        checkOutput({tag, ".rdy"}, 32'(arbIf.cpx_data_rdy_cx), 32'(expRdy));
    endtask

    // Two cycles of reset with idle inputs, then confirm all outputs are 0.
    task automatic doReset(input string tag);
        reset                = 1'b1;
        arbIf.src_req_cq     = '0;
        arbIf.src_atom_cq    = '0;
        arbIf.spc_credit_ret = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput({tag, ".rst.grant"}, 32'(arbIf.cpx_grant_ca), 32'd0);
        checkOutput({tag, ".rst.rdy"}, 32'(arbIf.cpx_data_rdy_cx), 32'd0);
        checkOutput({tag, ".rst.err"}, 32'(arbIf.arb_err), 32'd0);
    endtask

    initial begin
        arbIf.src_req_cq     = '0;
        arbIf.src_atom_cq    = '0;
        arbIf.spc_credit_ret = 1'b0;

        // Single request from src 2, then credit exhaustion and return.
        doReset("single");
        applyStimulus("single.r0", 5'b00100, 5'b0, 1'b0, 5'b00000, 1'b0);
        applyStimulus("single.r1", 5'b00000, 5'b0, 1'b0, 5'b00100, 1'b0);
        applyStimulus("single.r2", 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b1);
        applyStimulus("single.r3", 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b0);
        applyStimulus("single.r4", 5'b00011, 5'b0, 1'b0, 5'b00000, 1'b0);
        applyStimulus("single.r5", 5'b00000, 5'b0, 1'b0, 5'b00001, 1'b0);
        applyStimulus("single.r6", 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b1);
        applyStimulus("single.r7", 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b0);
        applyStimulus("single.r8", 5'b00000, 5'b0, 1'b1, 5'b00000, 1'b0);
        applyStimulus("single.r9", 5'b00000, 5'b0, 1'b0, 5'b00010, 1'b0);
        applyStimulus("single.r10", 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b1);

        // All five request, no credit return: only two grants.
        doReset("five");
        applyStimulus("five.r0", 5'b11111, 5'b0, 1'b0, 5'b00000, 1'b0);
        applyStimulus("five.r1", 5'b00000, 5'b0, 1'b0, 5'b00001, 1'b0);
        applyStimulus("five.r2", 5'b00000, 5'b0, 1'b0, 5'b00010, 1'b1);
        applyStimulus("five.r3", 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b1);
        applyStimulus("five.r4", 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b0);

        // All five request with a credit returned every cycle.
        doReset("fivecr");
        applyStimulus("fivecr.r0", 5'b11111, 5'b0, 1'b0, 5'b00000, 1'b0);
        applyStimulus("fivecr.r1", 5'b00000, 5'b0, 1'b1, 5'b00001, 1'b0);
        applyStimulus("fivecr.r2", 5'b00000, 5'b0, 1'b1, 5'b00010, 1'b1);
        applyStimulus("fivecr.r3", 5'b00000, 5'b0, 1'b1, 5'b00100, 1'b1);
        applyStimulus("fivecr.r4", 5'b00000, 5'b0, 1'b1, 5'b01000, 1'b1);
        applyStimulus("fivecr.r5", 5'b00000, 5'b0, 1'b1, 5'b10000, 1'b1);
        applyStimulus("fivecr.r6", 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b1);
        applyStimulus("fivecr.r7", 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b0);

        // Atomic pair on src 1 with src 0 and 3 waiting behind the lock.
        doReset("atom");
        applyStimulus("atom.r0", 5'b00010, 5'b00010, 1'b0, 5'b00000, 1'b0);
        applyStimulus("atom.r1", 5'b01001, 5'b00000, 1'b0, 5'b00010, 1'b0);
        applyStimulus("atom.r2", 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1);
        applyStimulus("atom.r3", 5'b00010, 5'b00000, 1'b0, 5'b00000, 1'b0);
        applyStimulus("atom.r4", 5'b00000, 5'b00000, 1'b0, 5'b00010, 1'b0);
        applyStimulus("atom.r5", 5'b00000, 5'b00000, 1'b1, 5'b01000, 1'b1);
        applyStimulus("atom.r6", 5'b00000, 5'b00000, 1'b0, 5'b00001, 1'b1);
        applyStimulus("atom.r7", 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1);
        applyStimulus("atom.r8", 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0);

        // Reset in the middle of an atomic pair.
        doReset("midrst");
        applyStimulus("midrst.r0", 5'b00010, 5'b00010, 1'b0, 5'b00000, 1'b0);
        applyStimulus("midrst.r1", 5'b00000, 5'b00000, 1'b0, 5'b00010, 1'b0);
        reset                = 1'b1;
        arbIf.src_req_cq     = '0;
        arbIf.src_atom_cq    = '0;
        arbIf.spc_credit_ret = 1'b0;
        tick();
        reset = 1'b0;
        checkOutput("midrst.hit.grant", 32'(arbIf.cpx_grant_ca), 32'd0);
        checkOutput("midrst.hit.rdy", 32'(arbIf.cpx_data_rdy_cx), 32'd0);
        checkOutput("midrst.hit.err", 32'(arbIf.arb_err), 32'd0);
        applyStimulus("midrst.r3", 5'b10000, 5'b00000, 1'b0, 5'b00000, 1'b0);
        applyStimulus("midrst.r4", 5'b00011, 5'b00000, 1'b0, 5'b10000, 1'b0);
        applyStimulus("midrst.r5", 5'b00000, 5'b00000, 1'b0, 5'b00001, 1'b1);
        applyStimulus("midrst.r6", 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1);
        applyStimulus("midrst.r7", 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0);

        // Third request to src 0 while it is starved of credit.
        doReset("err");
        applyStimulus("err.r0", 5'b00110, 5'b0, 1'b0, 5'b00000, 1'b0);
        applyStimulus("err.r1", 5'b00001, 5'b0, 1'b0, 5'b00010, 1'b0);
        checkOutput("err.r1.err", 32'(arbIf.arb_err), 32'd0);
        applyStimulus("err.r2", 5'b00001, 5'b0, 1'b0, 5'b00100, 1'b1);
        checkOutput("err.r2.err", 32'(arbIf.arb_err), 32'd0);
        applyStimulus("err.r3", 5'b00001, 5'b0, 1'b0, 5'b00000, 1'b1);
        checkOutput("err.r3.err", 32'(arbIf.arb_err), 32'(ERR_EXP));
        applyStimulus("err.r4", 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b0);
        checkOutput("err.r4.err", 32'(arbIf.arb_err), 32'(ERR_EXP));
        applyStimulus("err.r5", 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b0);
        checkOutput("err.r5.err", 32'(arbIf.arb_err), 32'(ERR_EXP));
        doReset("errclr");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/cpx_dest_arb.md
# cpx_dest_arb

Per-destination CPX arbiter: sequences packets from the four L2 banks (scache0–3) and the IO bridge onto one SPARC core's CPX return port. It tracks per-source pending requests, enforces destination buffer credits, holds atomic packet pairs back-to-back, and produces the one-hot source grant plus the core-side data-ready strobe. One instance sits beside each core's CPX buffer chain, driving the grant and data-ready signals that propagate through the buffer stages.

## Interface
- NSRC, 5, number of sources; index 0–3 = scache0–3, 4 = IO.
- QDEPTH, 2, destination buffer entries (credits) and per-source queue depth.

- rclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- src_req_cq  in  NSRC  per-source packet request pulse; one packet per source per cycle.
- src_atom_cq  in  NSRC  qualifies src_req_cq; set = first packet of an atomic pair.
- spc_credit_ret  in  1  destination freed one buffer entry.
- cpx_grant_ca  out  NSRC  registered one-hot grant; zero or one bit set.
- cpx_data_rdy_cx  out  1  grant delayed one cycle; packet valid at the core.
- arb_err  out  1  sticky protocol error (see Configuration).

## Operation
- Per-source queue: QDEPTH-entry FIFO of atom bits plus count. Request pushes; grant of that source pops.
- Credit counter: width $clog2(QDEPTH+1), resets to QDEPTH. Grant −1, spc_credit_ret +1; both in one cycle → unchanged.
- Eligible source: queue count > 0 and credit > 0.
- Round-robin: pointer resets to 0; search starts at pointer, first eligible wins; pointer moves to winner+1 mod NSRC.
- Atomic lock: granting an entry with atom=1 sets lock to that source. While locked, only the locked source may be granted; others stall even if eligible. Lock clears when the locked source's next entry is granted. Pointer does not advance on the first packet of a pair.
- Locked source queue empty or credit = 0: no grant, lock held.
- Simultaneous push and pop on one source: count unchanged, FIFO order preserved.
- Reset (any cycle, including mid-pair): queues emptied, credits = QDEPTH, lock cleared, pointer = 0, all outputs 0.

## Timing
- Request sampled in cycle t; queue visible t+1; earliest cpx_grant_ca in t+2 (registered); cpx_data_rdy_cx in t+3.
- Credit returned in cycle t usable for grant decision in t+1.
- Back-to-back grants every cycle while eligible sources and credits exist.
- Atomic pair with both requests in consecutive cycles: grants in consecutive cycles, no interleaving.
- Reset values: cpx_grant_ca = 0, cpx_data_rdy_cx = 0, arb_err = 0.

## Configuration
- CPX_ARB_ERR_EN defined: arb_err sets (sticky until reset) on request to a full source queue (request dropped), on spc_credit_ret with credit = QDEPTH (ignored), or on a non-atom request arriving while that source's tail entry is an unpaired atom first half.
- Undefined: checks not built; arb_err tied 0; overflow requests dropped, excess credit returns ignored silently.

## Structure
- Package cpx_arb_pkg: NSRC, QDEPTH, source index constants (SRC_SC0..SRC_SC3, SRC_IO), credit-width localparam.
- Sub-module cpx_src_q: one source's queue (count, atom FIFO, full/empty, overflow flag); instantiated NSRC times. Arbiter, lock, credit logic in top.

## Test plan
- Single request src 2 at t=0 → cpx_grant_ca=5'b00100 at t=2, cpx_data_rdy_cx=1 at t=3; credit 2→1.
- All five sources request at t=0 → grants 0,1,2,3,4 at t=2..6 only while credits last; with credit returned each cycle, all five granted consecutively.
- No credit returns, three requests → exactly two grants, third waits; spc_credit_ret pulse → third granted next-but-one cycle.
- src 1 atom pair (atom=1 at t=0, atom=0 at t=3) with src 0 and 3 requesting → src 1 granted, then stall until second packet, then src 1 again; no src 0/3 grant between.
- Reset asserted mid-pair → all outputs 0 next cycle, lock cleared, credits = 2; new src 4 request granted normally.
- CPX_ARB_ERR_EN: third request to src 0 with none granted → arb_err=1 and stays 1 until reset; without macro arb_err stays 0.
